// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - Y86-64 shared constants, status codes and memory-stage types
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;

  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } mem_state_e;

  typedef struct packed {
    logic access;
    logic write;
    logic addr_from_vala;
  } mem_op_t;

  // Stack pops (ret/popq) address memory through valA; everything else uses valE.
  function automatic mem_op_t decode_mem_op(input logic [3:0] icode);
    mem_op_t op;
    op = '0;
    case (icode)
      IRMMOVQ, ICALL, IPUSHQ: begin
        op.access = 1'b1;
        op.write  = 1'b1;
      end
      IMRMOVQ: op.access = 1'b1;
      IRET, IPOPQ: begin
        op.access         = 1'b1;
        op.addr_from_vala = 1'b1;
      end
      default: op = '0;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - loadable down-counter bounding the data-memory ack wait
module mem_wait_timer #(
  parameter int unsigned WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             en_i,
  output logic             expired_o
);

  logic [WIDTH-1:0] count_q;

  assign expired_o = (count_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (en_i && count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - Y86-64 memory stage: data-memory handshake FSM feeding the W register
module mem_access_stage
  import y86_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 8192,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        M_valid,
  input  logic [3:0]  M_icode,
  input  logic [2:0]  M_stat,
  input  logic [63:0] M_valE,
  input  logic [63:0] M_valA,
  input  logic [3:0]  M_dstE,
  input  logic [3:0]  M_dstM,
  input  logic        M_cnd,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [63:0] dmem_addr,
  output logic [63:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic        dmem_err,
  input  logic [63:0] dmem_rdata,
  output logic        m_stall,
  output logic        W_valid,
  output logic [3:0]  W_icode,
  output logic [2:0]  W_stat,
  output logic [63:0] W_valE,
  output logic [63:0] W_valM,
  output logic [3:0]  W_dstE,
  output logic [3:0]  W_dstM,
  output logic        W_cnd
);

  localparam logic [63:0]     MAX_ADDR  = 64'(MEM_BYTES - 8);
  localparam int unsigned     TW        = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]   WAIT_LOAD = TW'(TIMEOUT - 1);

  mem_state_e  state_q;
  logic        halted_q;
  logic        req_q, we_q;
  logic [63:0] addr_q, wdata_q;

  logic        w_valid_q, w_cnd_q;
  logic [3:0]  w_icode_q, w_dstE_q, w_dstM_q;
  logic [2:0]  w_stat_q;
  logic [63:0] w_valE_q, w_valM_q;

  logic        w_load;
  logic [2:0]  w_stat_d;
  logic [63:0] w_valM_d;
  logic [3:0]  w_dstE_d, w_dstM_d;

  mem_op_t     op;
  logic [63:0] op_addr;
  logic        op_active, start, fault, expired, resolve;

  mem_wait_timer #(.WIDTH(TW)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (start),
    .load_val_i (WAIT_LOAD),
    .en_i       (state_q == S_WAIT),
    .expired_o  (expired)
  );

  always_comb begin
    op        = decode_mem_op(M_icode);
    op_addr   = op.addr_from_vala ? M_valA : M_valE;
    op_active = op.access && M_valid && (M_stat == SAOK) && !halted_q;
    start     = (state_q == S_IDLE) && op_active && (op_addr <= MAX_ADDR);
    fault     = (state_q == S_IDLE) && op_active && (op_addr > MAX_ADDR);
    // Ack outranks a timeout landing in the same cycle.
    resolve   = (state_q == S_WAIT) && (dmem_ack || expired);
    m_stall   = start || ((state_q == S_WAIT) && !resolve);
  end

  always_comb begin
    w_load   = 1'b0;
    w_stat_d = M_stat;
    w_valM_d = '0;
    w_dstE_d = M_dstE;
    w_dstM_d = M_dstM;
    if (state_q == S_IDLE) begin
      w_load = !start;
      if (fault) begin
        w_stat_d = SADR;
        w_dstE_d = RNONE;
        w_dstM_d = RNONE;
      end
    end else if (resolve) begin
      w_load = 1'b1;
      if (dmem_ack && !dmem_err) begin
        w_stat_d = SAOK;
        w_valM_d = we_q ? 64'd0 : dmem_rdata;
      end else begin
        w_stat_d = SADR;
        w_dstE_d = RNONE;
        w_dstM_d = RNONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      halted_q  <= 1'b0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      w_valid_q <= 1'b0;
      w_icode_q <= '0;
      w_stat_q  <= '0;
      w_valE_q  <= '0;
      w_valM_q  <= '0;
      w_dstE_q  <= RNONE;
      w_dstM_q  <= RNONE;
      w_cnd_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          state_q <= S_WAIT;
          req_q   <= 1'b1;
          we_q    <= op.write;
          addr_q  <= op_addr;
          wdata_q <= M_valA;
        end
        S_WAIT: if (resolve) begin
          state_q <= S_IDLE;
          req_q   <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
      if (w_load) begin
        w_valid_q <= M_valid;
        w_icode_q <= M_icode;
        w_stat_q  <= w_stat_d;
        w_valE_q  <= M_valE;
        w_valM_q  <= w_valM_d;
        w_dstE_q  <= w_dstE_d;
        w_dstM_q  <= w_dstM_d;
        w_cnd_q   <= M_cnd;
        halted_q  <= halted_q | (M_valid && (w_stat_d != SAOK));
      end
    end
  end

  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign W_valid    = w_valid_q;
  assign W_icode    = w_icode_q;
  assign W_stat     = w_stat_q;
  assign W_valE     = w_valE_q;
  assign W_valM     = w_valM_q;
  assign W_dstE     = w_dstE_q;
  assign W_dstM     = w_dstM_q;
  assign W_cnd      = w_cnd_q;

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory stage of the pipelined Y86-64 processor. It consumes the M-register fields produced downstream of execute (`valE`, `cnd`, `icode`, `valA`, destinations, status). It performs the data-memory read or write over a req/ack handshake with a variable-latency data memory. It produces the W pipeline register for write-back and a stall signal for pipeline control. Non-memory instructions pass through in one cycle; memory instructions stall the pipeline until the memory acknowledges, errors, or times out.

## Interface
- `MEM_BYTES`, default 8192: valid data addresses are `0 .. MEM_BYTES-8`; anything else is an address error.
- `TIMEOUT`, default 64: maximum cycles to wait for `dmem_ack` before flagging an address error.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `M_valid` in 1: M register holds a real instruction (0 = bubble).
- `M_icode` in 4: instruction code.
- `M_stat` in 3: incoming status (AOK=1, HLT=2, ADR=3, INS=4).
- `M_valE` in 64: ALU result.
- `M_valA` in 64: store data or pop/ret address.
- `M_dstE` in 4: register destination for `valE`.
- `M_dstM` in 4: register destination for `valM` (F = none).
- `M_cnd` in 1: condition result from execute; passed through.
- `dmem_req` out 1: memory request; held until ack.
- `dmem_we` out 1: 1 = write, 0 = read.
- `dmem_addr` out 64: byte address.
- `dmem_wdata` out 64: write data.
- `dmem_ack` in 1: request complete this cycle.
- `dmem_err` in 1: valid only with ack; memory rejected the access.
- `dmem_rdata` in 64: read data, valid with ack.
- `m_stall` out 1: upstream must hold M and freeze earlier stages.
- `W_valid`, `W_icode`, `W_stat`, `W_valE`, `W_valM`, `W_dstE`, `W_dstM`, `W_cnd` out: W pipeline register. Widths are 1/4/3/64/64/4/4/1.

## Operation
- Access decode:
  - write at `M_valE` for rmmovq (4), call (8), pushq (10);
  - read at `M_valE` for mrmovq (5);
  - read at `M_valA` for ret (9), popq (11);
  - all other icodes: no access.
- Write data is always `M_valA`.
- Any access is suppressed (passes through as a no-access instruction) when any of these holds:
  - `M_valid`=0;
  - `M_stat`≠AOK;
  - sticky `halted` is set (a non-AOK status has already been loaded into W).
- Address check: if `addr > MEM_BYTES-8`, no request is issued. W loads in one cycle with `stat`=ADR, `W_dstE` and `W_dstM` forced to F.
- FSM states:
  - **IDLE**. A legal access starts: latch addr/we/wdata into output registers, go to **WAIT**. Otherwise load W from M.
  - **WAIT**. `dmem_req`=1, outputs stable.
    - `dmem_ack`=1 and `dmem_err`=0: load W with `valM`=`dmem_rdata` (reads) or 0 (writes), stat AOK, then go to IDLE.
    - `dmem_ack`=1 and `dmem_err`=1: load W with stat ADR and dsts=F, then go to IDLE.
    - Wait counter reaches `TIMEOUT` without ack: same as the error case, then drop `req` and go to IDLE.
- `m_stall`, combinational, is 1 in either case:
  - (IDLE and a legal access starts);
  - (WAIT and not (ack or timeout)).
- While stalled, W holds its value; the stage emits no bubble into W.
- `halted` is set when W loads a non-AOK stat. It is cleared only by reset.
- `W_valM` is 0 for all non-read instructions.

## Timing
- Reset: all W fields and `dmem_*` outputs go to 0, `W_dstE`/`W_dstM`=F, state IDLE, counter 0, `halted`=0. `m_stall` is 0 after reset.
- Non-access instruction: W updates at the first edge, latency 1.
- Access: the start cycle T has `m_stall`=1, and `dmem_req` rises at T+1. With ack sampled in cycle T+k (k≥1), W updates at the end of T+k. `m_stall` is 0 in T+k, so minimum latency is 2 cycles.
- Ack is never sampled in the start cycle T (`req` is not yet asserted).
- Timeout: the ack-wait counter counts cycles with `req` high. The error is taken in the cycle the counter equals `TIMEOUT`-1 with no ack.
- Ack and timeout in the same cycle: ack wins.
- `rst_n` asserted mid-WAIT: `req` drops immediately (asynchronous), and the transaction is abandoned with no W update.

## Structure
- Shared package `y86_pkg`:
  - icode constants (IHALT..IPOPQ);
  - stat codes AOK/HLT/ADR/INS;
  - `RNONE`=4'hF;
  - state enum.
  The fetch and execute stages also import it.
- One natural sub-module: `mem_wait_timer`, a loadable down-counter with an expiry flag.

## Test plan
- irmovq (3), `valE`=0x40, `dstE`=2 → W at next edge: `valE`=0x40, `dstE`=2, `valM`=0, `m_stall` never high.
- mrmovq, `valE`=0x100, ack after 3 cycles with rdata=0xDEADBEEF → `req` high 3 cycles, `we`=0, addr 0x100, `m_stall` high 3 cycles, W `valM`=0xDEADBEEF, stat AOK.
- pushq, `valE`=0x1F8, `valA`=0x55, ack immediately → `we`=1, addr 0x1F8, wdata 0x55, latency 2, `W_valM`=0.
- rmmovq, `valE`=`MEM_BYTES` → no `req`, W stat ADR next edge, dsts F. A following rmmovq produces no `req` (`halted`).
- popq, `valA`=0x200, no ack for `TIMEOUT` cycles → W stat ADR after 64 `req` cycles, `req` drops. Separately, a read with ack+err → stat ADR.
- Assert `rst_n` low on the 2nd WAIT cycle → `req` goes low with no clock edge, W stays reset, and the next instruction after release proceeds normally.
